// File: rtl/lock_session_if.sv
// Signal bundle between the keypad decoder, the entry/compare datapath and the
// lock session controller; i_/o_ directions are from the controller's side.
interface lock_session_if;
  logic       i_key_valid;
  logic [3:0] i_key_code;
  logic       i_code_match;
  logic       o_entry_shift;
  logic [3:0] o_entry_digit;
  logic       o_entry_clr;
  logic       o_unlocked;
  logic       o_alarm;
  logic       o_locked_out;
  logic [2:0] o_fail_cnt;
  logic [2:0] o_state;

  modport slave (
    input  i_key_valid, i_key_code, i_code_match,
    output o_entry_shift, o_entry_digit, o_entry_clr,
    output o_unlocked, o_alarm, o_locked_out, o_fail_cnt, o_state
  );

  modport master (
    output i_key_valid, i_key_code, i_code_match,
    input  o_entry_shift, o_entry_digit, o_entry_clr,
    input  o_unlocked, o_alarm, o_locked_out, o_fail_cnt, o_state
  );
endinterface

// File: rtl/lock_session_ctrl.sv
// Keypad lock session controller: sequences digit entry, code check, unlock,
// alarm, entry timeout and lockout, and tracks consecutive failed attempts.
module lock_session_ctrl #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned MAX_FAILS      = 6,
  parameter int unsigned ALARM_CYCLES   = 150_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000
) (
  input  logic          clk,
  input  logic          rst,
  lock_session_if.slave bus
);
  localparam int unsigned MAX_AU = (ALARM_CYCLES > UNLOCK_CYCLES) ? ALARM_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned MAX_TL = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned MAX_T  = (MAX_AU > MAX_TL) ? MAX_AU : MAX_TL;
  localparam int          TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int          CW     = $clog2(DIGITS + 1);

  // Timers count 0..N-1 from state entry, so the state is left exactly N cycles later.
  localparam logic [TW-1:0] T_ALARM   = TW'(ALARM_CYCLES - 1);
  localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_FULL    = CW'(DIGITS);
  localparam logic [2:0]    F_MAX     = 3'(MAX_FAILS);
  localparam logic [2:0]    F_RELOCK  = 3'(MAX_FAILS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_ALARM   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t        r_state, w_state_nx, w_fail_state;
  logic [CW-1:0] r_count, w_count_nx;
  logic [TW-1:0] r_timer, w_timer_nx, w_limit;
  logic [2:0]    r_fail, w_fail_nx, w_fail_inc;
  logic [3:0]    r_digit, w_digit_nx;
  logic          r_shift, w_shift_nx, r_clr, w_clr_nx;
  logic          r_unlocked, r_alarm, r_locked_out;
  logic          w_expired, w_key_digit, w_key_enter, w_key_clear, w_key_admin;

  assign w_key_digit = bus.i_key_valid && (bus.i_key_code <= 4'd9);
  assign w_key_enter = bus.i_key_valid && (bus.i_key_code == 4'd10);
  assign w_key_clear = bus.i_key_valid && (bus.i_key_code == 4'd11);
  assign w_key_admin = bus.i_key_valid && (bus.i_key_code == 4'd12);

  assign w_fail_inc   = (r_fail >= F_MAX) ? F_MAX : r_fail + 3'd1;
  assign w_fail_state = (w_fail_inc == F_MAX) ? S_LOCKOUT : S_ALARM;

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_ENTRY:   w_limit = T_TIMEOUT;
      S_OPEN:    w_limit = T_UNLOCK;
      S_ALARM:   w_limit = T_ALARM;
      S_LOCKOUT: w_limit = T_LOCKOUT;
      default:   w_limit = '0;
    endcase
  end

  assign w_expired = (r_timer == w_limit);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_timer_nx = r_timer + 1'b1;
    w_fail_nx  = r_fail;
    w_digit_nx = r_digit;
    w_shift_nx = 1'b0;
    w_clr_nx   = 1'b0;

    if (w_key_admin) begin
      w_state_nx = S_IDLE;
      w_count_nx = '0;
      w_fail_nx  = '0;
      w_clr_nx   = 1'b1;
      w_timer_nx = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_timer_nx = '0;
          if (w_key_digit) begin
            w_shift_nx = 1'b1;
            w_digit_nx = bus.i_key_code;
            w_count_nx = CW'(1);
            w_state_nx = S_ENTRY;
          end else if (w_key_clear) begin
            w_clr_nx = 1'b1;
          end
        end
        S_ENTRY: begin
          // A key accepted on the expiry cycle wins over the timeout.
          if (w_key_digit && (r_count < C_FULL)) begin
            w_shift_nx = 1'b1;
            w_digit_nx = bus.i_key_code;
            w_count_nx = r_count + 1'b1;
            w_timer_nx = '0;
          end else if (w_key_enter && (r_count == C_FULL)) begin
            w_state_nx = S_CHECK;
          end else if (w_key_enter) begin
            w_fail_nx  = w_fail_inc;
            w_state_nx = w_fail_state;
            w_clr_nx   = 1'b1;
            w_count_nx = '0;
          end else if (w_key_clear || w_expired) begin
            w_clr_nx   = 1'b1;
            w_count_nx = '0;
            w_state_nx = S_IDLE;
          end
        end
        S_CHECK: begin
          w_clr_nx   = 1'b1;
          w_count_nx = '0;
          if (bus.i_code_match) begin
            w_fail_nx  = '0;
            w_state_nx = S_OPEN;
          end else begin
            w_fail_nx  = w_fail_inc;
            w_state_nx = w_fail_state;
          end
        end
        S_OPEN: begin
          if (w_expired || w_key_enter || w_key_clear) w_state_nx = S_IDLE;
        end
        S_ALARM: begin
          if (w_expired) w_state_nx = S_IDLE;
        end
        S_LOCKOUT: begin
          // Leave one attempt of headroom so the next failure relocks immediately.
          if (w_expired) begin
            w_state_nx = S_IDLE;
            w_fail_nx  = F_RELOCK;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    if (w_state_nx != r_state) w_timer_nx = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_timer      <= '0;
      r_fail       <= '0;
      r_digit      <= '0;
      r_shift      <= 1'b0;
      r_clr        <= 1'b0;
      r_unlocked   <= 1'b0;
      r_alarm      <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_count      <= w_count_nx;
      r_timer      <= w_timer_nx;
      r_fail       <= w_fail_nx;
      r_digit      <= w_digit_nx;
      r_shift      <= w_shift_nx;
      r_clr        <= w_clr_nx;
      r_unlocked   <= (w_state_nx == S_OPEN);
      r_alarm      <= (w_state_nx == S_ALARM) || (w_state_nx == S_LOCKOUT);
      r_locked_out <= (w_state_nx == S_LOCKOUT);
    end
  end

  assign bus.o_state       = r_state;
  assign bus.o_entry_shift = r_shift;
  assign bus.o_entry_digit = r_digit;
  assign bus.o_entry_clr   = r_clr;
  assign bus.o_unlocked    = r_unlocked;
  assign bus.o_alarm       = r_alarm;
  assign bus.o_locked_out  = r_locked_out;
  assign bus.o_fail_cnt    = r_fail;
endmodule

// File: tb/tb_lock_session_ctrl.sv
// Scoreboard bench for lock_session_ctrl: directed key sequences push the
// expected (cycle, state, pulse, fail count) events; a negedge monitor pops and compares.
module tb_lock_session_ctrl;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_OPEN  = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;
  localparam logic [2:0] ST_LOCK  = 3'd5;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       shift;
    logic [3:0] digit;
    logic       clr;
    logic [2:0] fail;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   ev_n = 0;
  logic [2:0] prev_st = 3'd0;
  ev_t  exp_q[$];
  ev_t  m_e;

  lock_session_if bus();

  lock_session_ctrl #(
    .DIGITS(3), .MAX_FAILS(3), .ALARM_CYCLES(8), .UNLOCK_CYCLES(10),
    .TIMEOUT_CYCLES(16), .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int c, input logic [2:0] st, input logic sh,
                           input logic [3:0] d, input logic cl, input logic [2:0] f);
    ev_t e;
    e.cyc = c; e.st = st; e.shift = sh; e.digit = d; e.clr = cl; e.fail = f;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.i_key_valid = 1'b1;
    bus.i_key_code  = k;
    tick();
    bus.i_key_valid = 1'b0;
    bus.i_key_code  = 4'd0;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) tick();
  endtask

  // Three wrong digits plus Enter; a digit poked mid-penalty must be ignored.
  task automatic bad_attempt(input logic [2:0] f_before, input logic [2:0] f_after,
                             input logic [2:0] st_after, input int dur, input logic [2:0] f_exit);
    int t;
    t = cyc;
    expect_ev(t + 1, ST_ENTRY, 1'b1, 4'd1, 1'b0, f_before);
    expect_ev(t + 2, ST_ENTRY, 1'b1, 4'd1, 1'b0, f_before);
    expect_ev(t + 3, ST_ENTRY, 1'b1, 4'd1, 1'b0, f_before);
    expect_ev(t + 4, ST_CHECK, 1'b0, 4'd0, 1'b0, f_before);
    expect_ev(t + 5, st_after, 1'b0, 4'd0, 1'b1, f_after);
    expect_ev(t + 5 + dur, ST_IDLE, 1'b0, 4'd0, 1'b0, f_exit);
    press(4'd1); press(4'd1); press(4'd1); press(4'd10);
    idle_until(t + 7);
    press(4'd3);
    idle_until(t + 6 + dur);
  endtask

  // One digit then an early Enter: failure without a CHECK cycle.
  task automatic quick_fail(input logic [2:0] f_before, input logic [2:0] f_after,
                            input logic [2:0] st_after);
    int t;
    t = cyc;
    expect_ev(t + 1, ST_ENTRY, 1'b1, 4'd1, 1'b0, f_before);
    expect_ev(t + 2, st_after, 1'b0, 4'd0, 1'b1, f_after);
    press(4'd1); press(4'd10);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_state !== prev_st || bus.o_entry_shift === 1'b1 || bus.o_entry_clr === 1'b1) begin
        ev_n++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected event at cycle %0d: state=%0d shift=%0b clr=%0b",
                   cyc, bus.o_state, bus.o_entry_shift, bus.o_entry_clr);
        end else begin
          m_e = exp_q.pop_front();
          check($sformatf("ev%0d cycle", ev_n), cyc, m_e.cyc);
          check($sformatf("ev%0d state", ev_n), bus.o_state, m_e.st);
          check($sformatf("ev%0d entry_shift", ev_n), bus.o_entry_shift, m_e.shift);
          if (m_e.shift) check($sformatf("ev%0d entry_digit", ev_n), bus.o_entry_digit, m_e.digit);
          check($sformatf("ev%0d entry_clr", ev_n), bus.o_entry_clr, m_e.clr);
          check($sformatf("ev%0d fail_cnt", ev_n), bus.o_fail_cnt, m_e.fail);
          check($sformatf("ev%0d unlocked", ev_n), bus.o_unlocked, m_e.st == ST_OPEN);
          check($sformatf("ev%0d alarm", ev_n), bus.o_alarm, (m_e.st == ST_ALARM) || (m_e.st == ST_LOCK));
          check($sformatf("ev%0d locked_out", ev_n), bus.o_locked_out, m_e.st == ST_LOCK);
        end
      end
      prev_st = bus.o_state;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.i_key_valid  = 1'b0;
    bus.i_key_code   = 4'd0;
    bus.i_code_match = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset state", bus.o_state, ST_IDLE);
    check("reset entry_shift", bus.o_entry_shift, 1'b0);
    check("reset entry_clr", bus.o_entry_clr, 1'b0);
    check("reset entry_digit", bus.o_entry_digit, 4'd0);
    check("reset unlocked", bus.o_unlocked, 1'b0);
    check("reset alarm", bus.o_alarm, 1'b0);
    check("reset locked_out", bus.o_locked_out, 1'b0);
    check("reset fail_cnt", bus.o_fail_cnt, 3'd0);
    prev_st = bus.o_state;
    mon_en  = 1'b1;

    // Correct code 2,4,6: open for exactly 10 cycles; a digit in OPEN is ignored.
    bus.i_code_match = 1'b1;
    t = cyc;
    expect_ev(t + 1,  ST_ENTRY, 1'b1, 4'd2, 1'b0, 3'd0);
    expect_ev(t + 2,  ST_ENTRY, 1'b1, 4'd4, 1'b0, 3'd0);
    expect_ev(t + 3,  ST_ENTRY, 1'b1, 4'd6, 1'b0, 3'd0);
    expect_ev(t + 4,  ST_CHECK, 1'b0, 4'd0, 1'b0, 3'd0);
    expect_ev(t + 5,  ST_OPEN,  1'b0, 4'd0, 1'b1, 3'd0);
    expect_ev(t + 15, ST_IDLE,  1'b0, 4'd0, 1'b0, 3'd0);
    press(4'd2); press(4'd4); press(4'd6); press(4'd10);
    idle_until(t + 7);
    press(4'd7);
    idle_until(t + 17);

    // IDLE: Enter ignored, Clear pulses entry_clr.
    t = cyc;
    expect_ev(t + 2, ST_IDLE, 1'b0, 4'd0, 1'b1, 3'd0);
    press(4'd10); press(4'd11); tick();

    // Three wrong codes: ALARM, ALARM, LOCKOUT, then IDLE with fail_cnt=2.
    bus.i_code_match = 1'b0;
    bad_attempt(3'd0, 3'd1, ST_ALARM, 8,  3'd1);
    bad_attempt(3'd1, 3'd2, ST_ALARM, 8,  3'd2);
    bad_attempt(3'd2, 3'd3, ST_LOCK,  20, 3'd2);

    // Admin in IDLE clears fail_cnt with an entry_clr pulse.
    t = cyc;
    expect_ev(t + 1, ST_IDLE, 1'b0, 4'd0, 1'b1, 3'd0);
    press(4'd12); tick();

    // Short entry 1,2 + Enter fails straight into ALARM.
    t = cyc;
    expect_ev(t + 1,  ST_ENTRY, 1'b1, 4'd1, 1'b0, 3'd0);
    expect_ev(t + 2,  ST_ENTRY, 1'b1, 4'd2, 1'b0, 3'd0);
    expect_ev(t + 3,  ST_ALARM, 1'b0, 4'd0, 1'b1, 3'd1);
    expect_ev(t + 11, ST_IDLE,  1'b0, 4'd0, 1'b0, 3'd1);
    press(4'd1); press(4'd2); press(4'd10);
    idle_until(t + 12);

    // Fourth digit dropped, then Clear.
    t = cyc;
    expect_ev(t + 1, ST_ENTRY, 1'b1, 4'd3, 1'b0, 3'd1);
    expect_ev(t + 2, ST_ENTRY, 1'b1, 4'd4, 1'b0, 3'd1);
    expect_ev(t + 3, ST_ENTRY, 1'b1, 4'd5, 1'b0, 3'd1);
    expect_ev(t + 5, ST_IDLE,  1'b0, 4'd0, 1'b1, 3'd1);
    press(4'd3); press(4'd4); press(4'd5); press(4'd6); press(4'd11); tick();

    // Entry timeout: IDLE at t+17, fail_cnt unchanged.
    t = cyc;
    expect_ev(t + 1,  ST_ENTRY, 1'b1, 4'd5, 1'b0, 3'd1);
    expect_ev(t + 17, ST_IDLE,  1'b0, 4'd0, 1'b1, 3'd1);
    press(4'd5);
    idle_until(t + 18);

    // Key on the expiry cycle wins and restarts the timeout.
    t = cyc;
    expect_ev(t + 1,  ST_ENTRY, 1'b1, 4'd5, 1'b0, 3'd1);
    expect_ev(t + 17, ST_ENTRY, 1'b1, 4'd7, 1'b0, 3'd1);
    expect_ev(t + 33, ST_IDLE,  1'b0, 4'd0, 1'b1, 3'd1);
    press(4'd5);
    idle_until(t + 16);
    press(4'd7);
    idle_until(t + 34);

    // Fail to 2, then to lockout, and Admin aborts the lockout.
    t = cyc;
    quick_fail(3'd1, 3'd2, ST_ALARM);
    expect_ev(t + 10, ST_IDLE, 1'b0, 4'd0, 1'b0, 3'd2);
    idle_until(t + 11);
    t = cyc;
    quick_fail(3'd2, 3'd3, ST_LOCK);
    expect_ev(t + 6, ST_IDLE, 1'b0, 4'd0, 1'b1, 3'd0);
    idle_until(t + 5);
    press(4'd12); tick();

    // Admin aborts ALARM.
    t = cyc;
    quick_fail(3'd0, 3'd1, ST_ALARM);
    expect_ev(t + 5, ST_IDLE, 1'b0, 4'd0, 1'b1, 3'd0);
    idle_until(t + 4);
    press(4'd12); tick();

    // rst during CHECK: IDLE next edge with fail_cnt cleared, no entry_clr.
    t = cyc;
    quick_fail(3'd0, 3'd1, ST_ALARM);
    expect_ev(t + 10, ST_IDLE, 1'b0, 4'd0, 1'b0, 3'd1);
    idle_until(t + 11);
    bus.i_code_match = 1'b1;
    t = cyc;
    expect_ev(t + 1, ST_ENTRY, 1'b1, 4'd2, 1'b0, 3'd1);
    expect_ev(t + 2, ST_ENTRY, 1'b1, 4'd4, 1'b0, 3'd1);
    expect_ev(t + 3, ST_ENTRY, 1'b1, 4'd6, 1'b0, 3'd1);
    expect_ev(t + 4, ST_CHECK, 1'b0, 4'd0, 1'b0, 3'd1);
    expect_ev(t + 5, ST_IDLE,  1'b0, 4'd0, 1'b0, 3'd0);
    press(4'd2); press(4'd4); press(4'd6); press(4'd10);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();

    // rst during OPEN.
    t = cyc;
    expect_ev(t + 1, ST_ENTRY, 1'b1, 4'd2, 1'b0, 3'd0);
    expect_ev(t + 2, ST_ENTRY, 1'b1, 4'd4, 1'b0, 3'd0);
    expect_ev(t + 3, ST_ENTRY, 1'b1, 4'd6, 1'b0, 3'd0);
    expect_ev(t + 4, ST_CHECK, 1'b0, 4'd0, 1'b0, 3'd0);
    expect_ev(t + 5, ST_OPEN,  1'b0, 4'd0, 1'b1, 3'd0);
    expect_ev(t + 8, ST_IDLE,  1'b0, 4'd0, 1'b0, 3'd0);
    press(4'd2); press(4'd4); press(4'd6); press(4'd10);
    idle_until(t + 7);
    rst = 1'b1; tick(); rst = 1'b0;
    idle_until(t + 20);

    check("queue drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_session_ctrl.md
# lock_session_ctrl

Session controller for the keypad password lock. It consumes decoded key strobes and sequences the digit-entry register: shift, clear, and check requests. It owns the unlock, alarm, timeout and lockout timing, plus the failed-attempt count. It sits between the keypad decoder and the entry/compare datapath, and drives the display-mode, unlock and buzzer-enable signals.

## Interface
- DIGITS, 3: digits per code; Enter is valid only after exactly this many.
- MAX_FAILS, 6: consecutive failures that force LOCKOUT.
- ALARM_CYCLES, 150_000_000: buzzer-on duration after a failure.
- UNLOCK_CYCLES, 250_000_000: open duration before auto-relock.
- TIMEOUT_CYCLES, 500_000_000: entry inactivity limit.
- LOCKOUT_CYCLES, 1_500_000_000: lockout duration. Timer width = clog2 of the largest timing parameter.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid on this cycle.
- key_code  in  4  0–9 digit, 10 Enter, 11 Clear, 12 Admin reset; 13–15 ignored.
- code_match  in  1  datapath compare of the current entry against the stored code.
- entry_shift  out  1  one-cycle pulse: shift entry_digit into the entry register.
- entry_digit  out  4  digit accompanying entry_shift.
- entry_clr  out  1  one-cycle pulse: blank the entry register.
- unlocked  out  1  high in OPEN.
- alarm  out  1  buzzer enable; high in ALARM and LOCKOUT.
- locked_out  out  1  high in LOCKOUT.
- fail_cnt  out  3  consecutive failures, saturating at MAX_FAILS.
- state  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, ALARM=4, LOCKOUT=5.

## Operation
- Reset: state=IDLE; every output 0; digit count and timer 0.
- Admin key (12), any state: entry_clr pulse, fail_cnt←0, go to IDLE. Admin has priority over every other event except rst.
- IDLE
  - Digit: entry_shift, count←1, go to ENTRY.
  - Clear: entry_clr.
  - Enter: ignored.
- ENTRY
  - Digit with count<DIGITS: entry_shift, count+1.
  - Digit with count=DIGITS: dropped.
  - Enter with count=DIGITS: go to CHECK.
  - Enter with count<DIGITS: treated as a failure, same path as a CHECK mismatch.
  - Clear: entry_clr, count←0, go to IDLE.
  - TIMEOUT_CYCLES with no accepted key: entry_clr, go to IDLE; fail_cnt unchanged.
- CHECK lasts exactly one cycle and samples code_match.
  - Match: fail_cnt←0, go to OPEN.
  - Mismatch: fail_cnt←fail_cnt+1 (saturating). Go to LOCKOUT if the new value equals MAX_FAILS, else ALARM.
  - entry_clr pulses on exit in both cases; count←0.
- OPEN: exit to IDLE after UNLOCK_CYCLES, or early on Enter/Clear. Digits are ignored.
- ALARM: lasts ALARM_CYCLES, then IDLE. Non-admin keys are ignored.
- LOCKOUT: lasts LOCKOUT_CYCLES, then IDLE with fail_cnt←MAX_FAILS-1, so one further failure relocks. Non-admin keys are ignored.
- Timer: cleared on every state entry and on every accepted key in ENTRY.

## Timing
- All outputs are registered. key_valid at cycle t → state, pulses and entry_digit visible at t+1.
- Pulses are exactly one cycle wide; entry_shift and entry_clr are never high together.
- Enter at t → CHECK at t+1 → code_match sampled at t+1 → OPEN/ALARM/LOCKOUT at t+2, with entry_clr high at t+2.
- A timed state entered at cycle s is left at s+N, where N is its *_CYCLES value.
- Entry timeout: last accepted key at t → IDLE at t+1+TIMEOUT_CYCLES.
- Key coincident with timer expiry:
  - ENTRY: the key wins and the timer restarts.
  - OPEN/ALARM/LOCKOUT: expiry wins and the key is dropped, unless it is Admin.
- rst mid-state: IDLE on the next edge, all outputs 0, no pulses.

## Test plan
Parameters for all scenarios: DIGITS=3, MAX_FAILS=3, ALARM=8, UNLOCK=10, TIMEOUT=16, LOCKOUT=20.

- Keys 2,4,6 then Enter, code_match=1 → three entry_shift pulses (digits 2,4,6); CHECK for one cycle; unlocked high for exactly 10 cycles; then IDLE; fail_cnt=0.
- Three wrong codes (code_match=0) → fail_cnt 1,2,3:
  - ALARM (alarm high 8 cycles) twice, then LOCKOUT with locked_out high for 20 cycles.
  - Digits during lockout produce no entry_shift.
  - After lockout: IDLE with fail_cnt=2.
- Keys 1,2 then Enter → failure path: fail_cnt=1, ALARM, entry_clr pulse. A 4th digit after 3 is dropped with no pulse.
- Key 5, then idle 16 cycles → entry_clr and IDLE at t+17, fail_cnt unchanged. A key landing on the expiry cycle restarts the timeout.
- Admin key (12) during LOCKOUT and during ALARM → IDLE next cycle, fail_cnt=0, entry_clr pulse.
- rst asserted in OPEN and in CHECK → IDLE next edge, all outputs 0.
